// File: rtl/rx_depack_if.sv
// Byte-stream input and FIFO-side output bundle of the receive depacketizer.
interface rx_depack_if;
    logic        rxdv;
    logic        rxer;
    logic [7:0]  rxbyte;
    logic        afull;
    logic [39:0] odata;
    logic        wren;
    logic        frame_ok;
    logic        frame_err;
    logic        frame_skip;

    // Source side: PHY byte stream and FIFO fill level
    modport master (
        output rxdv, rxer, rxbyte, afull,
        input  odata, wren, frame_ok, frame_err, frame_skip
    );

    // Depacketizer side
    modport slave (
        input  rxdv, rxer, rxbyte, afull,
        output odata, wren, frame_ok, frame_err, frame_skip
    );
endinterface

// File: rtl/rx_depack.sv
// Receive-side depacketizer: strips preamble/SFD/MAC header/FCS, checks
// EtherType and CRC-32, and repacks the payload into 40-bit sample words.
module rx_depack #(
    parameter logic [15:0] ETYPE     = 16'h88B5,
    parameter int unsigned MAX_WORDS = 300
) (
    input  logic        rxclk,
    input  logic        rstn,
    rx_depack_if.slave  bus
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    // Residue in this MSB-first register orientation (bit-reverse of DEBB20E3)
    localparam logic [31:0] CRC_RES  = 32'hC704DD7B;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam int unsigned HDR_W    = 4;
    localparam int unsigned WCNT_W   = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PAY,
        DROP
    } state_t;

    state_t              state;
    logic                armed;
    logic [31:0]         crc;
    logic [HDR_W-1:0]    hdr_cnt;
    logic [7:0]          etype_hi;
    logic [3:0][7:0]     dly;
    logic [2:0]          dly_cnt;
    logic [31:0]         word_buf;
    logic [2:0]          byte_idx;
    logic [WCNT_W-1:0]   word_cnt;
    logic                ovf;
    logic                excess;
    logic                err_pend;
    logic                skip_pend;
    logic [39:0]         odata_q;
    logic                wren_q;
    logic                frame_ok_q;
    logic                frame_err_q;
    logic                frame_skip_q;

    logic                commit_c;
    logic [7:0]          commit_byte_c;
    logic [39:0]         word_c;
    logic [4:0]          wb_lsb_c;
    logic [31:0]         crc_upd_c;

    // CRC-32 over one byte, bits consumed LSB first, register kept MSB-first
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) begin
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                r = {r[30:0], 1'b0};
            end
        end
        return r;
    endfunction

    // Oldest byte of the FCS-guard delay line and the word it would complete
    always_comb begin
        commit_c      = (dly_cnt == 3'd4);
        commit_byte_c = dly[3];
        word_c        = {commit_byte_c, word_buf};
        wb_lsb_c      = {byte_idx[1:0], 3'b000};
        crc_upd_c     = crc_next(crc, bus.rxbyte);
    end

    // Frame parser: state, CRC, delay line, word packing and status pulses
    always_ff @(posedge rxclk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            armed        <= 1'b0;
            crc          <= '0;
            hdr_cnt      <= '0;
            etype_hi     <= '0;
            dly          <= '0;
            dly_cnt      <= '0;
            word_buf     <= '0;
            byte_idx     <= '0;
            word_cnt     <= '0;
            ovf          <= 1'b0;
            excess       <= 1'b0;
            err_pend     <= 1'b0;
            skip_pend    <= 1'b0;
            odata_q      <= '0;
            wren_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_skip_q <= 1'b0;
        end else begin
            wren_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_skip_q <= 1'b0;

            // A partial frame in flight at reset release is ignored until rxdv drops
            if (!bus.rxdv) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.rxdv && armed && (bus.rxbyte == PRE_BYTE)) begin
                        state     <= PRE;
                        err_pend  <= 1'b0;
                        skip_pend <= 1'b0;
                        ovf       <= 1'b0;
                        excess    <= 1'b0;
                        dly_cnt   <= '0;
                        byte_idx  <= '0;
                        word_cnt  <= '0;
                        hdr_cnt   <= '0;
                    end
                end

                PRE: begin
                    if (!bus.rxdv) begin
                        state <= IDLE;
                    end else if (bus.rxbyte == SFD_BYTE) begin
                        state   <= HDR;
                        crc     <= CRC_INIT;
                        hdr_cnt <= '0;
                    end else if (bus.rxbyte != PRE_BYTE) begin
                        state <= DROP;
                    end
                end

                HDR: begin
                    // EtherType can only match on the last header byte, so no pulse here
                    if (!bus.rxdv) begin
                        state <= IDLE;
                    end else if (bus.rxer) begin
                        state <= DROP;
                    end else begin
                        crc     <= crc_upd_c;
                        hdr_cnt <= hdr_cnt + HDR_W'(1);
                        if (hdr_cnt == HDR_W'(12)) begin
                            etype_hi <= bus.rxbyte;
                        end
                        if (hdr_cnt == HDR_W'(13)) begin
                            if ({etype_hi, bus.rxbyte} == ETYPE) begin
                                state <= PAY;
                            end else begin
                                state     <= DROP;
                                skip_pend <= 1'b1;
                            end
                        end
                    end
                end

                PAY: begin
                    if (!bus.rxdv) begin
                        state <= IDLE;
                        if ((crc == CRC_RES) && (byte_idx == 3'd0) && !ovf && !excess) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (bus.rxer) begin
                        state    <= DROP;
                        err_pend <= 1'b1;
                    end else begin
                        crc <= crc_upd_c;
                        dly <= {dly[2:0], bus.rxbyte};
                        if (!commit_c) begin
                            dly_cnt <= dly_cnt + 3'd1;
                        end
                        // Commit the byte that now has four bytes behind it
                        if (commit_c) begin
                            if (byte_idx == 3'd4) begin
                                byte_idx <= '0;
                                if (word_cnt < WCNT_W'(MAX_WORDS)) begin
                                    word_cnt <= word_cnt + WCNT_W'(1);
                                    if (bus.afull) begin
                                        ovf <= 1'b1;
                                    end else begin
                                        wren_q  <= 1'b1;
                                        odata_q <= word_c;
                                    end
                                end else begin
                                    excess <= 1'b1;
                                end
                            end else begin
                                word_buf[wb_lsb_c +: 8] <= commit_byte_c;
                                byte_idx                <= byte_idx + 3'd1;
                            end
                        end
                    end
                end

                DROP: begin
                    if (!bus.rxdv) begin
                        state        <= IDLE;
                        frame_skip_q <= skip_pend;
                        frame_err_q  <= err_pend;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.odata      = odata_q;
    assign bus.wren       = wren_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_skip = frame_skip_q;

endmodule

// File: tb/tb_rx_depack.sv
// Scoreboard bench for rx_depack: frames built with a reference CRC, expected
// words queued at build time and compared against words captured from the FIFO port.
module tb_rx_depack;

    logic clk = 1'b0;
    logic rstn;
    rx_depack_if bus();

    rx_depack #(.ETYPE(16'h88B5), .MAX_WORDS(300)) dut (
        .rxclk (clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  fr[$];
    logic        fa[$];
    logic        fe[$];
    logic [39:0] exp_q[$];
    logic [39:0] obs_w[$];
    int          obs_c[$];

    int n_ok = 0, n_err = 0, n_skip = 0, n_multi = 0;
    int ok_cyc = -1;
    int pass_cnt = 0, tot_cnt = 0;
    int mark_idx = -1, mark_cyc = -1, end_cyc = -1;
    int rst_from = -1, rst_to = -1;

    // Capture FIFO writes and status pulses mid-cycle
    always @(negedge clk) begin
        if (bus.wren) begin
            obs_w.push_back(bus.odata);
            obs_c.push_back(cyc);
        end
        if (bus.frame_ok) begin
            n_ok++;
            ok_cyc = cyc;
        end
        if (bus.frame_err) n_err++;
        if (bus.frame_skip) n_skip++;
        if (int'(bus.frame_ok) + int'(bus.frame_err) + int'(bus.frame_skip) > 1) n_multi++;
    end

    task automatic build(input logic [15:0] et, input int npay, input bit push);
        logic [31:0] c;
        fr.delete(); fa.delete(); fe.delete();
        repeat (7) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 12; i++) fr.push_back(8'(8'h10 + i));
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        for (int p = 1; p <= npay; p++) fr.push_back(8'(p));
        c = 32'hFFFFFFFF;
        for (int i = 8; i < fr.size(); i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
        for (int i = 0; i < fr.size(); i++) begin
            fa.push_back(1'b0);
            fe.push_back(1'b0);
        end
        if (push) begin
            for (int w = 0; w < npay / 5; w++)
                exp_q.push_back({8'(5*w+5), 8'(5*w+4), 8'(5*w+3), 8'(5*w+2), 8'(5*w+1)});
        end
    endtask

    task automatic send();
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            bus.rxdv   = 1'b1;
            bus.rxbyte = fr[i];
            bus.afull  = fa[i];
            bus.rxer   = fe[i];
            rstn       = !(i >= rst_from && i < rst_to);
            if (i == mark_idx) mark_cyc = cyc + 1;
        end
        @(negedge clk);
        bus.rxdv   = 1'b0;
        bus.rxer   = 1'b0;
        bus.afull  = 1'b0;
        bus.rxbyte = 8'h00;
        rstn       = 1'b1;
        end_cyc    = cyc + 1;
    endtask

    task automatic test_reset();
        bus.rxdv = 1'b0; bus.rxer = 1'b0; bus.rxbyte = 8'h00; bus.afull = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if ({bus.wren, bus.frame_ok, bus.frame_err, bus.frame_skip} !== 4'b0000)
            $display("FAIL reset_strobes got=%b exp=0000", {bus.wren, bus.frame_ok, bus.frame_err, bus.frame_skip});
        else pass_cnt++;
        tot_cnt++;
        if (bus.odata !== 40'h0) $display("FAIL reset_odata got=%h exp=0", bus.odata);
        else pass_cnt++;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        int first;
        logic [39:0] e, o;
        build(16'h88B5, 10, 1'b1);
        mark_idx = 22 + 4;
        send();
        mark_idx = -1;
        repeat (4) @(negedge clk);
        first = (obs_c.size() > 0) ? obs_c[0] : -1;
        tot_cnt++;
        if (first !== mark_cyc + 4) $display("FAIL good_latency got=%0d exp=%0d", first, mark_cyc + 4);
        else pass_cnt++;
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h010000)
            $display("FAIL good_status ok/err/skip got=%0d/%0d/%0d exp=1/0/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (ok_cyc !== end_cyc) $display("FAIL good_pulse_time got=%0d exp=%0d", ok_cyc, end_cyc);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== exp_q.size()) $display("FAIL good_nwords got=%0d exp=%0d", obs_w.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_w.size() > 0) begin
            e = exp_q.pop_front(); o = obs_w.pop_front();
            tot_cnt++;
            if (o !== e) $display("FAIL good_word got=%h exp=%h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_bad_fcs();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        logic [39:0] e, o;
        build(16'h88B5, 10, 1'b1);
        fr[fr.size()-1] = fr[fr.size()-1] ^ 8'hFF;
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000100)
            $display("FAIL badfcs_status ok/err/skip got=%0d/%0d/%0d exp=0/1/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== exp_q.size()) $display("FAIL badfcs_nwords got=%0d exp=%0d", obs_w.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_w.size() > 0) begin
            e = exp_q.pop_front(); o = obs_w.pop_front();
            tot_cnt++;
            if (o !== e) $display("FAIL badfcs_word got=%h exp=%h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_wrong_etype();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        build(16'h0800, 10, 1'b0);
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000001)
            $display("FAIL etype_status ok/err/skip got=%0d/%0d/%0d exp=0/0/1", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== 0) $display("FAIL etype_nwords got=%0d exp=0", obs_w.size());
        else pass_cnt++;
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_overflow();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        logic [39:0] e, o;
        build(16'h88B5, 10, 1'b1);
        void'(exp_q.pop_back());
        for (int i = 32; i < 36; i++) fa[i] = 1'b1;
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000100)
            $display("FAIL ovf_status ok/err/skip got=%0d/%0d/%0d exp=0/1/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== exp_q.size()) $display("FAIL ovf_nwords got=%0d exp=%0d", obs_w.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_w.size() > 0) begin
            e = exp_q.pop_front(); o = obs_w.pop_front();
            tot_cnt++;
            if (o !== e) $display("FAIL ovf_word got=%h exp=%h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_rxer();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        build(16'h88B5, 10, 1'b0);
        fe[24] = 1'b1;
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000100)
            $display("FAIL rxer_status ok/err/skip got=%0d/%0d/%0d exp=0/1/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== 0) $display("FAIL rxer_nwords got=%0d exp=0", obs_w.size());
        else pass_cnt++;
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_length();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        logic [39:0] e, o;
        build(16'h88B5, 11, 1'b1);
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000100)
            $display("FAIL len_status ok/err/skip got=%0d/%0d/%0d exp=0/1/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== exp_q.size()) $display("FAIL len_nwords got=%0d exp=%0d", obs_w.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_w.size() > 0) begin
            e = exp_q.pop_front(); o = obs_w.pop_front();
            tot_cnt++;
            if (o !== e) $display("FAIL len_word got=%h exp=%h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_reset_mid();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        build(16'h88B5, 10, 1'b0);
        // After release, feed what would look like a fresh preamble/SFD
        fr[27] = 8'h55; fr[28] = 8'h55; fr[29] = 8'hD5;
        rst_from = 25; rst_to = 27;
        send();
        rst_from = -1; rst_to = -1;
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h000000)
            $display("FAIL rstmid_status ok/err/skip got=%0d/%0d/%0d exp=0/0/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== 0) $display("FAIL rstmid_nwords got=%0d exp=0", obs_w.size());
        else pass_cnt++;
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_back_to_back();
        int b_ok = n_ok, b_err = n_err, b_skip = n_skip;
        logic [39:0] e, o;
        build(16'h88B5, 10, 1'b1);
        send();
        build(16'h88B5, 15, 1'b1);
        send();
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ({8'(n_ok-b_ok), 8'(n_err-b_err), 8'(n_skip-b_skip)} !== 24'h020000)
            $display("FAIL b2b_status ok/err/skip got=%0d/%0d/%0d exp=2/0/0", n_ok-b_ok, n_err-b_err, n_skip-b_skip);
        else pass_cnt++;
        tot_cnt++;
        if (obs_w.size() !== exp_q.size()) $display("FAIL b2b_nwords got=%0d exp=%0d", obs_w.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_w.size() > 0) begin
            e = exp_q.pop_front(); o = obs_w.pop_front();
            tot_cnt++;
            if (o !== e) $display("FAIL b2b_word got=%h exp=%h", o, e);
            else pass_cnt++;
        end
        exp_q.delete(); obs_w.delete(); obs_c.delete();
    endtask

    task automatic test_exclusive();
        tot_cnt++;
        if (n_multi !== 0) $display("FAIL status_exclusive got=%0d overlaps exp=0", n_multi);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_wrong_etype();
        test_overflow();
        test_rxer();
        test_length();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/rx_depack.md
# rx_depack

Receive-side depacketizer for the Ethernet sample link. It runs in the `rxclk` domain behind the RGMII DDR input stage, which delivers one byte per cycle. It strips preamble, SFD, MAC header and FCS, and checks the EtherType and CRC-32. It unpacks the payload into 40-bit words, each holding four 10-bit samples, and writes them into the receive FIFO that feeds the DAC path. It is the inverse of the ADC→FIFO→`tx` packing path.

## Interface
- `ETYPE`, 16'h88B5: accepted EtherType. Other frames are skipped.
- `MAX_WORDS`, 300: maximum payload words per frame. Excess words make the frame an error.
- `rxclk` in 1: byte clock, 125 MHz.
- `rstn` in 1: reset, asynchronous, active-low.
- `rxdv` in 1: byte valid. High for the whole frame, from preamble to the last FCS byte.
- `rxer` in 1: receive error from the PHY, qualified by `rxdv`.
- `rxbyte` in 8: received byte.
- `afull` in 1: FIFO almost-full. A word is not written while it is high.
- `odata` out 40: packed word. Sample i is `odata[10i+9:10i]`.
- `wren` out 1: FIFO write strobe, one cycle per word.
- `frame_ok` out 1: one-cycle pulse for a good accepted frame.
- `frame_err` out 1: one-cycle pulse for an accepted frame with an error.
- `frame_skip` out 1: one-cycle pulse for a frame whose EtherType does not match.

## Operation
- The FSM has five states: IDLE, PRE, HDR, PAY, DROP.
- **IDLE:** when `rxdv`=1 and `rxbyte`=8'h55, go to PRE.
- **PRE:**
  - 8'h55 → stay in PRE.
  - 8'hD5 → go to HDR and preset the CRC to 32'hFFFFFFFF.
  - Any other byte → go to DROP, with no pulse.
- **HDR:** count 14 bytes. Bytes 12 and 13 form the EtherType, MSB first.
  - Mismatch → go to DROP and pulse `frame_skip` at frame end.
  - Match → go to PAY.
- **PAY:** each byte enters a 4-deep delay line. A byte is committed only when a fifth byte arrives behind it, so the final 4 bytes are always treated as FCS.
  - Committed bytes fill the word LSB first: the first byte goes to `odata[7:0]`, the fifth to `odata[39:32]`.
  - On the 5th committed byte the word is written.
- **CRC:** standard reflected Ethernet CRC-32 (poly 0x04C11DB7), computed over every byte from the destination MAC through the FCS. The frame is good when the residue equals 32'hC704DD7B.
- **Frame end** is the first cycle with `rxdv`=0 while in HDR, PAY or DROP.
  - Accepted frame: pulse `frame_ok` if all of the following hold; otherwise pulse `frame_err`:
    - CRC residue correct;
    - committed byte count is a multiple of 5;
    - no `rxer` seen;
    - no overflow;
    - word count ≤ MAX_WORDS.
  - The FSM then returns to IDLE.
- **`rxer`=1 in HDR or PAY:** go to DROP. The frame ends with `frame_err` if the EtherType had already matched; otherwise no pulse.
- **Overflow:** if `afull`=1 in the cycle the word would be written, the word is discarded (no `wren`) and the frame-overflow flag is set. Remaining words of the frame are still attempted.
- **Excess words:** words beyond MAX_WORDS are discarded and the frame is flagged as an error.
- **No retraction:** words already written are never retracted. Downstream uses `frame_err` to discard if it needs to.
- **`rxdv` low before PAY:** in IDLE or PRE this is silent. In HDR it pulses `frame_err` only if the EtherType had matched, which cannot happen before byte 13, so in practice there is no pulse.
- **Reset values:** all outputs 0, `odata`=40'h0, FSM in IDLE, CRC, counters and flags cleared. Reset mid-frame abandons the frame. After `rstn` rises the block waits for `rxdv`=0 before leaving IDLE, so a partial frame is never parsed.

## Timing
- Single clock, with all inputs sampled on the `rxclk` rising edge. `rxdv` is continuous within a frame, with no gaps.
- **Word latency:** let payload byte k be sampled at cycle t. If k is the 5th byte of a word, `wren` and the word on `odata` are high in cycle t+5, i.e. one cycle after byte k+4 is sampled.
- `odata` holds its value between writes.
- **Status latency:** `frame_ok`, `frame_err` and `frame_skip` are high in the cycle after the first `rxdv`=0 sample. They are mutually exclusive.
- **Back-to-back frames:** a new preamble may start on the cycle after `rxdv` falls. The status pulse and a new IDLE→PRE transition may coincide.
- The last payload word is written no later than the status pulse, in the same cycle or earlier.

## Test plan
1. **Good frame:** 7×55, D5, header with EtherType 88B5, 10 payload bytes 01..0A, then a valid FCS. Expect:
   - `wren` twice, with `odata`=40'h0504030201 then 40'h0A09080706;
   - `frame_ok` once;
   - the first write exactly 5 cycles after byte 05 is sampled.
2. **Bad FCS:** the same frame with the last FCS byte flipped. Expect both words written and `frame_err` pulsed, with no `frame_ok`.
3. **Wrong EtherType:** EtherType 0800. Expect no `wren` and `frame_skip` once.
4. **Overflow:** `afull` high during the second word's write cycle. Expect only word 1 written and `frame_err`.
5. **`rxer` and length errors:**
   - `rxer` asserted on payload byte 3 → `frame_err`, with no further `wren`.
   - An 11-byte payload → 2 words written and `frame_err`.
6. **Reset and back-to-back:**
   - `rstn` low mid-payload, then high while `rxdv` is still 1. Expect no `wren` or pulses until the next frame.
   - Two good frames separated by one idle cycle. Expect two `frame_ok` pulses and all words written.
